pkt_buf_ctrl: RTL and testbench

Store-and-forward controller for the eSRAM packet buffer on the datamover clock domain. Accepts Ethernet ingress flits, writes them into the buffer as a ring, commits only complete packets, and streams committed packets back out of the buffer to the egress interface under almost-full backpressure. Sits between the registered Ethernet-in stage and the eSRAM port registers, and drives the registered Ethernet-out stage.

---
 rtl/pkt_buf_ctrl_pkg.sv | 15 +
 rtl/pkt_buf_ctrl_rd.sv | 43 ++++
 rtl/pkt_buf_ctrl.sv | 112 +++++++++++
 tb/tb_pkt_buf_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_buf_ctrl_pkg.sv
// pkt_buf_ctrl_pkg: shared buffer geometry, flit layout and write FSM states for pkt_buf_ctrl
package pkt_buf_ctrl_pkg;
  localparam int PKTBUF_AWIDTH = 6;
  localparam int PKTBUF_DEPTH = 2 ** PKTBUF_AWIDTH;
  localparam int MAX_PKT_FLITS_DEF = 24;
  typedef logic [PKTBUF_AWIDTH:0] ptr_t;
  typedef logic [PKTBUF_AWIDTH-1:0] addr_t;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [5:0] empty;
    logic [511:0] data;
  } pkt_buf_flit_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DROP} wr_state_t;
endpackage

// File: rtl/pkt_buf_ctrl_rd.sv
// pkt_buf_rd_ctrl: issues buffer reads up to the commit pointer and registers the egress flit
module pkt_buf_rd_ctrl
  import pkt_buf_ctrl_pkg::*;
(
  input  logic          clk_datamover,
  input  logic          rst_datamover,
  input  ptr_t          commit_ptr,
  input  logic          out_almost_full,
  input  logic          rd_valid,
  input  pkt_buf_flit_t rddata,
  output logic          rden,
  output addr_t         rdaddress,
  output ptr_t          rd_ptr,
  output logic [511:0]  out_data,
  output logic [5:0]    out_empty,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_valid
);
  logic issue;
  assign issue = rd_ptr != commit_ptr && !out_almost_full;
  always_ff @(posedge clk_datamover) begin
    if (rst_datamover) begin
      rden <= 1'b0;
      rdaddress <= '0;
      rd_ptr <= '0;
      out_data <= '0;
      out_empty <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      rden <= issue;
      rdaddress <= addr_t'(rd_ptr);
      rd_ptr <= rd_ptr + ptr_t'(issue);
      out_valid <= rd_valid;
      out_sop <= rd_valid && rddata.sop;
      out_eop <= rd_valid && rddata.eop;
      out_data <= rd_valid ? rddata.data : out_data;
      out_empty <= rd_valid ? rddata.empty : out_empty;
    end
  end
endmodule

// File: rtl/pkt_buf_ctrl.sv
// pkt_buf_ctrl: store-and-forward eSRAM ring buffer controller; saturating stats when PKT_BUF_STATS_EN is defined
module pkt_buf_ctrl
  import pkt_buf_ctrl_pkg::*;
#(
  parameter int MAX_PKT_FLITS = MAX_PKT_FLITS_DEF
) (
  input  logic                     clk_datamover,
  input  logic                     rst_datamover,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic                     in_valid,
  input  logic [511:0]             in_data,
  input  logic [5:0]               in_empty,
  output logic                     esram_pkt_buf_wren,
  output logic [PKTBUF_AWIDTH-1:0] esram_pkt_buf_wraddress,
  output logic [519:0]             esram_pkt_buf_wrdata,
  output logic                     esram_pkt_buf_rden,
  output logic [PKTBUF_AWIDTH-1:0] esram_pkt_buf_rdaddress,
  input  logic                     esram_pkt_buf_rd_valid,
  input  logic [519:0]             esram_pkt_buf_rddata,
  output logic [511:0]             out_data,
  output logic [5:0]               out_empty,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_valid,
  input  logic                     out_almost_full,
  output logic [PKTBUF_AWIDTH:0]   occupancy,
  output logic [31:0]              stat_pkt_in,
  output logic [31:0]              stat_drop_full,
  output logic [31:0]              stat_drop_err
);
  localparam int CW = $clog2(MAX_PKT_FLITS + 1);
  wr_state_t state, state_nx;
  ptr_t wr_ptr, commit_ptr, pkt_start, rd_ptr, base_ptr;
  logic [CW-1:0] cnt;
  logic rb_sop, admit, cont, wr, commit, trunc;
  always_comb begin
    rb_sop = state == WR_WRITE && in_valid && in_sop;
    base_ptr = rb_sop ? pkt_start : wr_ptr;
    admit = in_valid && in_sop && ptr_t'(base_ptr - rd_ptr) <= ptr_t'(PKTBUF_DEPTH - MAX_PKT_FLITS);
    cont = state == WR_WRITE && in_valid && !in_sop;
    wr = admit || cont;
    commit = wr && in_eop;
    trunc = cont && !in_eop && cnt == CW'(MAX_PKT_FLITS - 1);
    state_nx = state;
    if (in_valid && in_sop)
      state_nx = in_eop ? WR_IDLE : (admit ? WR_WRITE : WR_DROP);
    else if (cont)
      state_nx = in_eop ? WR_IDLE : (trunc ? WR_DROP : WR_WRITE);
    else if (state == WR_DROP && in_valid && in_eop)
      state_nx = WR_IDLE;
  end
  always_ff @(posedge clk_datamover) begin
    if (rst_datamover) begin
      state <= WR_IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      pkt_start <= '0;
      cnt <= '0;
      esram_pkt_buf_wren <= 1'b0;
      esram_pkt_buf_wraddress <= '0;
      esram_pkt_buf_wrdata <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= trunc ? pkt_start : base_ptr + ptr_t'(wr);
      commit_ptr <= commit ? base_ptr + ptr_t'(1) : commit_ptr;
      pkt_start <= admit ? base_ptr : pkt_start;
      cnt <= admit ? CW'(1) : cnt + CW'(cont);
      esram_pkt_buf_wren <= wr;
      esram_pkt_buf_wraddress <= addr_t'(base_ptr);
      esram_pkt_buf_wrdata <= {in_sop, in_eop, in_empty, in_data};
    end
  end
  assign occupancy = wr_ptr - rd_ptr;
  pkt_buf_rd_ctrl u_rd (
    .clk_datamover   (clk_datamover),
    .rst_datamover   (rst_datamover),
    .commit_ptr      (commit_ptr),
    .out_almost_full (out_almost_full),
    .rd_valid        (esram_pkt_buf_rd_valid),
    .rddata          (esram_pkt_buf_rddata),
    .rden            (esram_pkt_buf_rden),
    .rdaddress       (esram_pkt_buf_rdaddress),
    .rd_ptr          (rd_ptr),
    .out_data        (out_data),
    .out_empty       (out_empty),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_valid       (out_valid)
  );
`ifdef PKT_BUF_STATS_EN
  logic inc_pkt, inc_full, inc_err;
  assign inc_pkt = commit;
  assign inc_full = in_valid && in_sop && !admit;
  assign inc_err = (state == WR_IDLE && in_valid && !in_sop) || rb_sop || trunc;
  always_ff @(posedge clk_datamover) begin
    if (rst_datamover) begin
      stat_pkt_in <= '0;
      stat_drop_full <= '0;
      stat_drop_err <= '0;
    end else begin
      stat_pkt_in <= stat_pkt_in + 32'(inc_pkt && ~&stat_pkt_in);
      stat_drop_full <= stat_drop_full + 32'(inc_full && ~&stat_drop_full);
      stat_drop_err <= stat_drop_err + 32'(inc_err && ~&stat_drop_err);
    end
  end
`else
  assign stat_pkt_in = '0;
  assign stat_drop_full = '0;
  assign stat_drop_err = '0;
`endif
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb_pkt_buf_ctrl: directed checks of pkt_buf_ctrl against a 1-cycle eSRAM model
module tb_pkt_buf_ctrl;
  import pkt_buf_ctrl_pkg::*;
`ifdef PKT_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
  logic [511:0] in_data = '0;
  logic [5:0] in_empty = '0;
  logic wren, rden, rd_valid = 1'b0;
  logic [PKTBUF_AWIDTH-1:0] wraddress, rdaddress;
  logic [519:0] wrdata, rddata = '0;
  logic [511:0] out_data;
  logic [5:0] out_empty;
  logic out_sop, out_eop, out_valid, out_almost_full = 1'b0;
  logic [PKTBUF_AWIDTH:0] occupancy;
  logic [31:0] stat_pkt_in, stat_drop_full, stat_drop_err;
  logic [519:0] mem [PKTBUF_DEPTH];
  logic [519:0] out_q[$];
  logic [PKTBUF_AWIDTH-1:0] wa_q[$], ra_q[$];
  int errors = 0, checks = 0;

  pkt_buf_ctrl dut (
    .clk_datamover           (clk),
    .rst_datamover           (rst),
    .in_sop                  (in_sop),
    .in_eop                  (in_eop),
    .in_valid                (in_valid),
    .in_data                 (in_data),
    .in_empty                (in_empty),
    .esram_pkt_buf_wren      (wren),
    .esram_pkt_buf_wraddress (wraddress),
    .esram_pkt_buf_wrdata    (wrdata),
    .esram_pkt_buf_rden      (rden),
    .esram_pkt_buf_rdaddress (rdaddress),
    .esram_pkt_buf_rd_valid  (rd_valid),
    .esram_pkt_buf_rddata    (rddata),
    .out_data                (out_data),
    .out_empty               (out_empty),
    .out_sop                 (out_sop),
    .out_eop                 (out_eop),
    .out_valid               (out_valid),
    .out_almost_full         (out_almost_full),
    .occupancy               (occupancy),
    .stat_pkt_in             (stat_pkt_in),
    .stat_drop_full          (stat_drop_full),
    .stat_drop_err           (stat_drop_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren) mem[wraddress] <= wrdata;
    rd_valid <= rden;
    if (rden) rddata <= mem[rdaddress];
  end

  always @(negedge clk) begin
    if (wren) wa_q.push_back(wraddress);
    if (rden) ra_q.push_back(rdaddress);
    if (out_valid) out_q.push_back({out_sop, out_eop, out_empty, out_data});
  end

  task automatic chk(input string tag, input logic [519:0] got, input logic [519:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [519:0] ef(input int id, input int i, input int n);
    logic last;
    last = i == n - 1;
    return {i == 0, last, last ? 6'(id) : 6'd0, {32{16'(id * 256 + i)}}};
  endfunction

  task automatic pkt(input int id, input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sop = i == 0;
      in_eop = close && i == n - 1;
      in_empty = in_eop ? 6'(id) : 6'd0;
      in_data = {32{16'(id * 256 + i)}};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((occupancy != 0 || rden || rd_valid || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_drain"}, occupancy, 0);
  endtask

  task automatic exp_pkt(input string tag, input int id, input int n);
    for (int i = 0; i < n; i++)
      chk(tag, out_q.size() > 0 ? out_q.pop_front() : 520'd0, ef(id, i, n));
  endtask

  initial begin
    int stalled;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {wren, rden, out_valid, out_sop, out_eop}, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stats", {stat_pkt_in, stat_drop_full, stat_drop_err}, 0);

    // single-flit packet: exact cycle timing
    pkt(1, 1, 1'b1);
    idle(1);
    chk("t1_wr", {wren, wraddress}, {1'b1, 6'd0});
    chk("t1_wrdata", wrdata, ef(1, 0, 1));
    idle(1);
    chk("t1_rd", {rden, rdaddress, wren}, {1'b1, 6'd0, 1'b0});
    idle(2);
    chk("t1_out", {out_valid, out_sop, out_eop, out_empty, out_data}, {1'b1, ef(1, 0, 1)});
    chk("t1_stat", stat_pkt_in, STATS ? 1 : 0);
    drain("t1");
    out_q.delete();

    // fill to DEPTH-23 flits, then a 24-flit packet must be refused at sop
    out_almost_full = 1'b1;
    pkt(2, 20, 1'b1);
    pkt(3, 21, 1'b1);
    idle(3);
    chk("t2_occ_fill", occupancy, 41);
    wa_q.delete();
    pkt(4, 24, 1'b1);
    idle(3);
    chk("t2_no_wren", wa_q.size(), 0);
    chk("t2_occ_same", occupancy, 41);
    chk("t2_drop_full", stat_drop_full, STATS ? 1 : 0);
    out_almost_full = 1'b0;
    drain("t2");
    exp_pkt("t2_p2", 2, 20);
    exp_pkt("t2_p3", 3, 21);
    chk("t2_extra", out_q.size(), 0);

    // 25-flit packet truncated at 24 and rolled back (wr_ptr was 42)
    wa_q.delete();
    pkt(5, 25, 1'b1);
    idle(3);
    chk("t3_nwr", wa_q.size(), 24);
    chk("t3_addr_first", wa_q.size() > 0 ? wa_q[0] : 6'h3f, 42);
    chk("t3_addr_last", wa_q.size() > 23 ? wa_q[23] : 6'h3f, 1);
    chk("t3_occ", occupancy, 0);
    chk("t3_drop_err", stat_drop_err, STATS ? 1 : 0);
    wa_q.delete();
    pkt(6, 3, 1'b1);
    idle(2);
    drain("t3");
    chk("t3_reuse", wa_q.size() > 0 ? wa_q[0] : 6'h3f, 42);
    exp_pkt("t3_p6", 6, 3);
    chk("t3_extra", out_q.size(), 0);

    // sop on the third flit of an open packet (start at 45)
    wa_q.delete();
    pkt(7, 2, 1'b0);
    pkt(8, 3, 1'b1);
    idle(2);
    drain("t4");
    chk("t4_restart", wa_q.size() > 2 ? wa_q[2] : 6'h3f, 45);
    exp_pkt("t4_p8", 8, 3);
    chk("t4_extra", out_q.size(), 0);
    chk("t4_drop_err", stat_drop_err, STATS ? 2 : 0);

    // back-to-back packets wrapping past address 63 with a 10-cycle stall
    wa_q.delete();
    ra_q.delete();
    stalled = 0;
    fork
      begin
        pkt(9, 8, 1'b1);
        pkt(10, 8, 1'b1);
        pkt(11, 8, 1'b1);
        idle(2);
      end
      begin
        repeat (12) @(negedge clk);
        chk("t5_active", rden, 1'b1);
        out_almost_full = 1'b1;
        repeat (10) begin
          @(negedge clk);
          stalled += int'(rden);
        end
        out_almost_full = 1'b0;
        @(negedge clk);
        chk("t5_resume", rden, 1'b1);
      end
    join
    chk("t5_stall", stalled, 0);
    drain("t5");
    chk("t5_wr_63", wa_q.size() > 15 ? wa_q[15] : 6'h0, 63);
    chk("t5_wr_wrap", wa_q.size() > 16 ? wa_q[16] : 6'h3f, 0);
    chk("t5_rd_wrap", ra_q.size() > 16 ? ra_q[16] : 6'h3f, 0);
    chk("t5_rd_n", ra_q.size(), 24);
    exp_pkt("t5_p9", 9, 8);
    exp_pkt("t5_p10", 10, 8);
    exp_pkt("t5_p11", 11, 8);
    chk("t5_extra", out_q.size(), 0);

    // reset in the middle of a packet with a committed packet still buffered
    out_almost_full = 1'b1;
    pkt(12, 4, 1'b1);
    pkt(13, 2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sop = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ctl", {wren, rden, out_valid, out_sop, out_eop, out_empty}, 0);
    chk("t6_addr", {wraddress, rdaddress, occupancy}, 0);
    chk("t6_wrdata", wrdata, 0);
    chk("t6_outdata", out_data, 0);
    chk("t6_stats", {stat_pkt_in, stat_drop_full, stat_drop_err}, 0);
    rst = 1'b0;
    out_almost_full = 1'b0;
    out_q.delete();
    wa_q.delete();
    pkt(14, 2, 1'b1);
    idle(2);
    drain("t6");
    chk("t6_addr0", wa_q.size() > 0 ? wa_q[0] : 6'h3f, 0);
    exp_pkt("t6_p14", 14, 2);
    chk("t6_extra", out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
